mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Sequencer for the 16-lane multiplier layer.
- Accepts one vector command at a time and steps through it in 16-lane beats. Each beat's operands come from one of two sources: hot/cold buffer reads (sel_in=1) or adder-layer feedback data (sel_in=0).
- Drives the multiplier's sel_in and shift_right controls for the whole command.
- Captures the multiplier's combinational result into a credit-protected result FIFO with valid/ready output.

Parameters:
- WIDTH, 32, lane data width.
- LANES, 16, lanes per beat.
- ADDR_W, 10, hot/cold buffer address width (one address = one 16-lane row).
- LEN_W, 10, command length width, in beats.
- BUF_LAT, 2, hot/cold buffer read latency in cycles (>=1).
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_mode  in  1  1=buffer mode (hot x cold), 0=feedback mode (pre_data)
- cmd_shift  in  8  right-shift amount for the command
- cmd_len  in  LEN_W  number of beats
- cmd_hot_base  in  ADDR_W  first hot row
- cmd_cold_base  in  ADDR_W  first cold row
- hot_rd_en  out  1  hot buffer read strobe
- hot_rd_addr  out  ADDR_W  hot buffer row
- cold_rd_en  out  1  cold buffer read strobe
- cold_rd_addr  out  ADDR_W  cold buffer row
- pre_valid  in  1  adder-layer beat available on multiplier pre_data
- pre_ready  out  1  feedback beat consumed when pre_valid&&pre_ready
- mul_sel  out  1  to multiplier sel_in
- mul_shift  out  8  to multiplier shift_right
- mul_out  in  LANES*WIDTH  multiplier result; lane i at [i*WIDTH +: WIDTH]
- res_valid  out  1  FIFO head valid
- res_ready  in  1  downstream accepts head
- res_data  out  LANES*WIDTH  FIFO head
- busy  out  1  state!=IDLE
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high.
  - On reset the block enters IDLE.
  - Output reset values: cmd_ready=1, hot_rd_en=cold_rd_en=0, addresses=0, pre_ready=0, mul_sel=1, mul_shift=0, res_valid=0, busy=0, done=0.
  - Reset clears the FIFO, the in-flight tracker and the beat counter.
  - Reset mid-command discards all in-flight and queued beats. No done pulse is produced.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept, register mode, shift, len, hot/cold base.
  - mul_sel<=cmd_mode and mul_shift<=cmd_shift. Both are held until the next accept.
  - If cmd_len==0, go to DRAIN with nothing in flight. done pulses the next cycle; no reads are issued.
  - Otherwise go to ISSUE.
- Credit rule:
  - inflight = buffer reads issued but not yet captured. count = FIFO occupancy.
  - credit = (inflight + count < FIFO_DEPTH).
  - credit ignores a same-cycle pop (conservative). The FIFO therefore never overflows; the bench asserts this.
- ISSUE, buffer mode:
  - Each cycle with credit, assert hot_rd_en and cold_rd_en together.
  - Addresses are base+beat_idx (mod 2^ADDR_W; wrap permitted). beat_idx then increments.
  - A BUF_LAT-deep valid shift register tracks each read. mul_out is captured into the FIFO in the cycle the tracker tail is set.
  - pre_ready=0.
- ISSUE, feedback mode:
  - No buffer reads.
  - pre_ready = credit.
  - On pre_valid&&pre_ready, mul_out is pushed the same cycle (zero latency) and beat_idx increments.
- ISSUE exit: after the last beat is issued/consumed, go to DRAIN.
- DRAIN:
  - No new reads; pre_ready=0.
  - When inflight==0 (last beat is in the FIFO), pulse done for one cycle, go to IDLE, cmd_ready=1.
  - A new command may start while the FIFO still holds results.
- FIFO:
  - Registered storage, first-word-fall-through: res_valid = count!=0, res_data = head.
  - Pop on res_valid&&res_ready.
  - Simultaneous push and pop leaves count unchanged; ordering is preserved.
  - res_ready while empty has no effect.
- mul_sel and mul_shift never change while a beat is in flight. This holds because commands are accepted only in IDLE, i.e. after DRAIN completes.
- busy=1 in ISSUE and DRAIN.

Test Plan:
- Buffer mode, len=3, hot_base=5, cold_base=9, BUF_LAT=2, res_ready=1 -> reads at addr 5/9, 6/10, 7/11 on consecutive cycles; three res_valid beats in order starting 3 cycles after the first read; done 1 cycle after the third capture; mul_sel=1.
- Buffer mode, len=8, res_ready=0 -> exactly 4 reads issued (FIFO_DEPTH); rd_en then held low; res_ready=1 resumes issue; all 8 results emerge in address order; no overflow.
- Feedback mode, shift=16, len=2, pre_valid pulsed twice with a gap -> mul_sel=0 and mul_shift=16 before the first beat; pre_ready high only with credit; two pushes; done after the second push.
- cmd_len=0 -> cmd accepted, no rd_en/pre_ready, done pulses exactly once, back to IDLE (cmd_ready=1) two cycles after accept.
- hot_base=1023, len=2 (ADDR_W=10) -> addresses 1023 then 0.
- rst asserted mid-command with 2 reads in flight and 1 FIFO entry -> next cycle rd_en=0, res_valid=0, busy=0, no done, mul_sel=1, mul_shift=0; a fresh command executes normally.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// Bus bundle for the multiplier-layer sequencer: command, buffer reads,
// feedback handshake, multiplier controls/result and the result stream.
interface mul_seq_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_mode;
    logic [7:0]             cmd_shift;
    logic [LEN_W-1:0]       cmd_len;
    logic [ADDR_W-1:0]      cmd_hot_base;
    logic [ADDR_W-1:0]      cmd_cold_base;
    logic                   hot_rd_en;
    logic [ADDR_W-1:0]      hot_rd_addr;
    logic                   cold_rd_en;
    logic [ADDR_W-1:0]      cold_rd_addr;
    logic                   pre_valid;
    logic                   pre_ready;
    logic                   mul_sel;
    logic [7:0]             mul_shift;
    logic [LANES*WIDTH-1:0] mul_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [LANES*WIDTH-1:0] res_data;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_valid, cmd_mode, cmd_shift, cmd_len, cmd_hot_base, cmd_cold_base,
        output pre_valid, mul_out, res_ready,
        input  cmd_ready, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr,
        input  pre_ready, mul_sel, mul_shift, res_valid, res_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_shift, cmd_len, cmd_hot_base, cmd_cold_base,
        input  pre_valid, mul_out, res_ready,
        output cmd_ready, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr,
        output pre_ready, mul_sel, mul_shift, res_valid, res_data, busy, done
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the 16-lane multiplier layer: steps a vector command in beats,
// sources operands from hot/cold buffers or adder feedback, and queues results.
module mul_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 16,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int BUF_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    mul_seq_ctrl_if.slave bus
);
    localparam int TRK_W = $clog2(BUF_LAT + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_sel;
    logic [7:0]             r_shift;
    logic [LEN_W-1:0]       r_len;
    logic [ADDR_W-1:0]      r_hot_base;
    logic [ADDR_W-1:0]      r_cold_base;
    logic [LEN_W-1:0]       r_beat_idx;
    logic [BUF_LAT-1:0]     r_track;
    logic [LANES*WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic [TRK_W-1:0]       w_inflight;
    logic                   w_credit;
    logic                   w_issue;
    logic                   w_pre_ready;
    logic                   w_pre_fire;
    logic                   w_beat;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_done;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < BUF_LAT; i++) begin
            w_inflight = w_inflight + TRK_W'(r_track[i]);
        end
    end

    // Credit counts reads still in the buffer pipeline so the FIFO cannot overflow.
    assign w_credit    = (32'(w_inflight) + 32'(r_count)) < 32'(FIFO_DEPTH);
    assign w_issue     = (r_state == S_ISSUE) && r_sel && w_credit;
    assign w_pre_ready = (r_state == S_ISSUE) && !r_sel && w_credit;
    assign w_pre_fire  = w_pre_ready && bus.pre_valid;
    assign w_beat      = w_issue || w_pre_fire;
    assign w_last      = (r_beat_idx == (r_len - LEN_W'(1)));
    assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_push      = r_track[BUF_LAT-1] || w_pre_fire;
    assign w_pop       = (r_count != '0) && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_next_state = (bus.cmd_len == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_beat && w_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_inflight == '0) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Multiplier controls are only reloaded on accept, so they stay fixed while beats are in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= 1'b1;
            r_shift     <= '0;
            r_len       <= '0;
            r_hot_base  <= '0;
            r_cold_base <= '0;
            r_beat_idx  <= '0;
        end else if (w_accept) begin
            r_sel       <= bus.cmd_mode;
            r_shift     <= bus.cmd_shift;
            r_len       <= bus.cmd_len;
            r_hot_base  <= bus.cmd_hot_base;
            r_cold_base <= bus.cmd_cold_base;
            r_beat_idx  <= '0;
        end else if (w_beat) begin
            r_beat_idx  <= r_beat_idx + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_track <= '0;
        end else begin
            r_track[0] <= w_issue;
            for (int i = 1; i < BUF_LAT; i++) begin
                r_track[i] <= r_track[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.mul_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.hot_rd_en    = w_issue;
    assign bus.cold_rd_en   = w_issue;
    assign bus.hot_rd_addr  = r_hot_base + ADDR_W'(r_beat_idx);
    assign bus.cold_rd_addr = r_cold_base + ADDR_W'(r_beat_idx);
    assign bus.pre_ready    = w_pre_ready;
    assign bus.mul_sel      = r_sel;
    assign bus.mul_shift    = r_shift;
    assign bus.res_valid    = (r_count != '0);
    assign bus.res_data     = r_mem[r_rd_ptr];
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = w_done;
endmodule
